// File: rtl/hms_timer_pkg.sv
// hms_timer_pkg: definitions shared by the hh/mm/ss timer and its prescaler.
//   hms_state_e : control FSM state (IDLE, RUN, DONE)
//   SEC_MAX     : last value of the seconds field before it carries or borrows
//   MIN_MAX     : last value of the minutes field before it carries or borrows
//   W_DEFAULT   : default width of each hh/mm/ss field
package hms_timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } hms_state_e;

   localparam int unsigned SEC_MAX   = 59;
   localparam int unsigned MIN_MAX   = 59;
   localparam int unsigned W_DEFAULT = 8;

endpackage

// File: rtl/hms_tick_prescaler.sv
// hms_tick_prescaler: divides ap_clk down to a one-cycle tick every TICK_DIV enabled cycles.
//   ap_clk : clock, rising edge
//   ap_rst : synchronous active-high reset
//   en     : count enable; the counter holds its value while low
//   clr    : synchronous clear to 0, dominates en
//   tick   : combinational, high while enabled and the counter is at TICK_DIV-1
module hms_tick_prescaler #(
   parameter int unsigned TICK_DIV = 100
) (
   input  logic ap_clk,
   input  logic ap_rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LastCnt = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_d, cnt_q;
   logic          at_last;

   assign at_last = (cnt_q == LastCnt);
   assign tick    = en && at_last;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = at_last ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/hms_timer.sv
// hms_timer: hh:mm:ss up/down timer with prescaler, preset load, lap hold, alarm and
// countdown-done detection.
//   ap_clk, ap_rst                 : clock and synchronous active-high reset
//   clear                          : zero time, prescaler, hold and done flag
//   start_r                        : run enable level (low pauses)
//   down                           : direction, sampled only on a tick
//   load, load_hh/mm/ss            : preset pulse and values (saturated into range)
//   lap                            : toggles the display hold
//   alarm_hh/mm/ss                 : alarm compare value
//   hh, mm, ss                     : registered displayed time
//   tick                           : pulse coincident with each displayed second update
//   running                        : high in RUN
//   alarm                          : pulse when the internal count takes the alarm value
//   zero                           : sticky countdown-done flag
module hms_timer
   import hms_timer_pkg::*;
#(
   parameter int unsigned TICK_DIV = 100,
   parameter int unsigned W        = W_DEFAULT,
   parameter int unsigned HH_MAX   = 23
) (
   input  logic         ap_clk,
   input  logic         ap_rst,
   input  logic         clear,
   input  logic         start_r,
   input  logic         down,
   input  logic         load,
   input  logic [W-1:0] load_hh,
   input  logic [W-1:0] load_mm,
   input  logic [W-1:0] load_ss,
   input  logic         lap,
   input  logic [W-1:0] alarm_hh,
   input  logic [W-1:0] alarm_mm,
   input  logic [W-1:0] alarm_ss,
   output logic [W-1:0] hh,
   output logic [W-1:0] mm,
   output logic [W-1:0] ss,
   output logic         tick,
   output logic         running,
   output logic         alarm,
   output logic         zero
);

   localparam logic [W-1:0] SecMax = W'(SEC_MAX);
   localparam logic [W-1:0] MinMax = W'(MIN_MAX);
   localparam logic [W-1:0] HhMax  = W'(HH_MAX);

   hms_state_e   state_d, state_q;
   logic [W-1:0] cnt_hh_d, cnt_hh_q, cnt_mm_d, cnt_mm_q, cnt_ss_d, cnt_ss_q;
   logic [W-1:0] hh_d, hh_q, mm_d, mm_q, ss_d, ss_q;
   logic         hold_d, hold_q, zero_d, zero_q, entry_d, entry_q;
   logic         tick_p_d, tick_p_q, tick_d, tick_q, alarm_d, alarm_q;

   logic         in_run, cnt_zero, cnt_one, entry_done;
   logic         pre_en, pre_tick, tick_eff;
   logic         disp_upd, go_done, new_val;
   logic [W-1:0] inc_hh, inc_mm, inc_ss, dec_hh, dec_mm, dec_ss;
   logic [W-1:0] sat_hh, sat_mm, sat_ss;

   assign in_run   = (state_q == RUN);
   assign cnt_zero = (cnt_hh_q == '0) && (cnt_mm_q == '0) && (cnt_ss_q == '0);
   assign cnt_one  = (cnt_hh_q == '0) && (cnt_mm_q == '0) && (cnt_ss_q == W'(1));
   // Entering RUN in down mode at 00:00:00 finishes immediately and never ticks.
   assign entry_done = in_run && entry_q && down && cnt_zero;
   assign pre_en     = in_run && !entry_done;
   // A clear or load discards a tick landing in the same cycle.
   assign tick_eff   = pre_tick && !clear && !load;

   hms_tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
      .en     (pre_en),
      .clr    (clear || load),
      .tick   (pre_tick)
   );

   // Carry / borrow chains and preset saturation.
   always_comb begin
      inc_hh = cnt_hh_q;
      inc_mm = cnt_mm_q;
      inc_ss = cnt_ss_q + W'(1);
      if (cnt_ss_q == SecMax) begin
         inc_ss = '0;
         inc_mm = cnt_mm_q + W'(1);
         if (cnt_mm_q == MinMax) begin
            inc_mm = '0;
            inc_hh = (cnt_hh_q == HhMax) ? '0 : cnt_hh_q + W'(1);
         end
      end

      dec_hh = cnt_hh_q;
      dec_mm = cnt_mm_q;
      dec_ss = cnt_ss_q - W'(1);
      if (cnt_ss_q == '0) begin
         dec_ss = SecMax;
         dec_mm = cnt_mm_q - W'(1);
         if (cnt_mm_q == '0) begin
            dec_mm = MinMax;
            dec_hh = (cnt_hh_q == '0) ? HhMax : cnt_hh_q - W'(1);
         end
      end

      sat_hh = (load_hh > HhMax)  ? HhMax  : load_hh;
      sat_mm = (load_mm > MinMax) ? MinMax : load_mm;
      sat_ss = (load_ss > SecMax) ? SecMax : load_ss;
   end

   always_comb begin
      state_d  = state_q;
      cnt_hh_d = cnt_hh_q;
      cnt_mm_d = cnt_mm_q;
      cnt_ss_d = cnt_ss_q;
      hold_d   = hold_q;
      zero_d   = zero_q;
      entry_d  = 1'b0;
      tick_p_d = 1'b0;
      disp_upd = !hold_q;
      go_done  = 1'b0;
      new_val  = 1'b0;

      if (clear) begin
         state_d  = IDLE;
         cnt_hh_d = '0;
         cnt_mm_d = '0;
         cnt_ss_d = '0;
         hold_d   = 1'b0;
         zero_d   = 1'b0;
      end else if (load) begin
         state_d  = IDLE;
         cnt_hh_d = sat_hh;
         cnt_mm_d = sat_mm;
         cnt_ss_d = sat_ss;
         hold_d   = 1'b0;
         zero_d   = 1'b0;
         new_val  = 1'b1;
      end else begin
         // Capturing on lap uses the pre-tick count, so a coincident tick is not shown.
         if (lap) begin
            hold_d   = !hold_q;
            disp_upd = 1'b1;
         end
         unique case (state_q)
            IDLE: begin
               if (start_r) begin
                  state_d = RUN;
                  entry_d = 1'b1;
               end
            end
            RUN: begin
               if (entry_done) begin
                  go_done = 1'b1;
               end else if (tick_eff) begin
                  if (down && cnt_zero) begin
                     go_done = 1'b1;
                  end else begin
                     cnt_hh_d = down ? dec_hh : inc_hh;
                     cnt_mm_d = down ? dec_mm : inc_mm;
                     cnt_ss_d = down ? dec_ss : inc_ss;
                     tick_p_d = 1'b1;
                     new_val  = 1'b1;
                     go_done  = down && cnt_one;
                  end
               end
               if (go_done) begin
                  state_d = DONE;
                  zero_d  = 1'b1;
               end else if (!start_r) begin
                  state_d = IDLE;
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      alarm_d = new_val && (cnt_hh_d == alarm_hh) && (cnt_mm_d == alarm_mm)
                && (cnt_ss_d == alarm_ss);
      hh_d    = disp_upd ? cnt_hh_q : hh_q;
      mm_d    = disp_upd ? cnt_mm_q : mm_q;
      ss_d    = disp_upd ? cnt_ss_q : ss_q;
      // Two stages so the pulse lines up with the registered display.
      tick_d  = tick_p_q;
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q  <= IDLE;
         cnt_hh_q <= '0;
         cnt_mm_q <= '0;
         cnt_ss_q <= '0;
         hh_q     <= '0;
         mm_q     <= '0;
         ss_q     <= '0;
         hold_q   <= 1'b0;
         zero_q   <= 1'b0;
         entry_q  <= 1'b0;
         tick_p_q <= 1'b0;
         tick_q   <= 1'b0;
         alarm_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_hh_q <= cnt_hh_d;
         cnt_mm_q <= cnt_mm_d;
         cnt_ss_q <= cnt_ss_d;
         hh_q     <= hh_d;
         mm_q     <= mm_d;
         ss_q     <= ss_d;
         hold_q   <= hold_d;
         zero_q   <= zero_d;
         entry_q  <= entry_d;
         tick_p_q <= tick_p_d;
         tick_q   <= tick_d;
         alarm_q  <= alarm_d;
      end
   end

   assign hh      = hh_q;
   assign mm      = mm_q;
   assign ss      = ss_q;
   assign tick    = tick_q;
   assign running = in_run;
   assign alarm   = alarm_q;
   assign zero    = zero_q;

endmodule

// File: tb/tb_hms_timer.sv
// tb_hms_timer: directed test-plan steps followed by random stimulus, every cycle compared
// against a model that keeps the time as a plain count of seconds.
module tb_hms_timer;

   localparam int unsigned TICK_DIV = 4;
   localparam int unsigned W        = 8;
   localparam int unsigned HH_MAX   = 23;
   localparam int DAY     = (HH_MAX + 1) * 3600;
   localparam int ST_IDLE = 0;
   localparam int ST_RUN  = 1;
   localparam int ST_DONE = 2;

   logic         ap_clk = 1'b0;
   logic         ap_rst, clear, start_r, down, load, lap;
   logic [W-1:0] load_hh, load_mm, load_ss, alarm_hh, alarm_mm, alarm_ss;
   logic [W-1:0] hh, mm, ss;
   logic         tick, running, alarm, zero;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int alarm_seen = 0;
   int tick_seen = 0;

   // Model state: time in seconds, prescaler, state, display (seconds) and pulse pipeline.
   int m_t = 0, m_pre = 0, m_st = ST_IDLE, m_entry = 0, m_hold = 0, m_zero = 0;
   int m_disp = 0, m_tickp = 0, m_tick = 0, m_alarm = 0;

   hms_timer #(
      .TICK_DIV (TICK_DIV),
      .W        (W),
      .HH_MAX   (HH_MAX)
   ) dut (
      .ap_clk   (ap_clk),
      .ap_rst   (ap_rst),
      .clear    (clear),
      .start_r  (start_r),
      .down     (down),
      .load     (load),
      .load_hh  (load_hh),
      .load_mm  (load_mm),
      .load_ss  (load_ss),
      .lap      (lap),
      .alarm_hh (alarm_hh),
      .alarm_mm (alarm_mm),
      .alarm_ss (alarm_ss),
      .hh       (hh),
      .mm       (mm),
      .ss       (ss),
      .tick     (tick),
      .running  (running),
      .alarm    (alarm),
      .zero     (zero)
   );

   always #5 ap_clk = ~ap_clk;

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic int is_alarm(input int t);
      return int'((t / 3600 == int'(alarm_hh)) && ((t / 60) % 60 == int'(alarm_mm))
                  && (t % 60 == int'(alarm_ss)));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_edge();
      int t_n, pre_n, st_n, hold_n, zero_n, disp_n, tickp_n, tick_n, alarm_n, entry_n;
      bit ez, tk;
      if (ap_rst) begin
         m_t = 0; m_pre = 0; m_st = ST_IDLE; m_entry = 0; m_hold = 0; m_zero = 0;
         m_disp = 0; m_tickp = 0; m_tick = 0; m_alarm = 0;
         return;
      end
      t_n = m_t; pre_n = m_pre; st_n = m_st; hold_n = m_hold; zero_n = m_zero;
      entry_n = 0; tickp_n = 0; alarm_n = 0;
      disp_n = (m_hold != 0) ? m_disp : m_t;
      tick_n = m_tickp;
      ez = (m_st == ST_RUN) && (m_entry != 0) && down && (m_t == 0);
      tk = (m_st == ST_RUN) && !ez && (m_pre == TICK_DIV - 1);
      if (m_st == ST_RUN && !ez) pre_n = (m_pre + 1) % TICK_DIV;
      if (clear) begin
         t_n = 0; pre_n = 0; st_n = ST_IDLE; hold_n = 0; zero_n = 0;
      end else if (load) begin
         t_n = sat(int'(load_hh), HH_MAX) * 3600 + sat(int'(load_mm), 59) * 60
               + sat(int'(load_ss), 59);
         pre_n = 0; st_n = ST_IDLE; hold_n = 0; zero_n = 0;
         alarm_n = is_alarm(t_n);
      end else begin
         if (lap) begin
            hold_n = (m_hold != 0) ? 0 : 1;
            disp_n = m_t;
         end
         if (m_st == ST_IDLE) begin
            if (start_r) begin
               st_n = ST_RUN;
               entry_n = 1;
            end
         end else if (m_st == ST_RUN) begin
            if (ez) begin
               st_n = ST_DONE; zero_n = 1;
            end else begin
               if (tk) begin
                  if (down && m_t == 0) begin
                     st_n = ST_DONE; zero_n = 1;
                  end else begin
                     t_n = down ? m_t - 1 : (m_t + 1) % DAY;
                     tickp_n = 1;
                     alarm_n = is_alarm(t_n);
                     if (down && t_n == 0) begin
                        st_n = ST_DONE; zero_n = 1;
                     end
                  end
               end
               if (st_n == ST_RUN && !start_r) st_n = ST_IDLE;
            end
         end
      end
      m_t = t_n; m_pre = pre_n; m_st = st_n; m_hold = hold_n; m_zero = zero_n;
      m_entry = entry_n; m_disp = disp_n; m_tickp = tickp_n; m_tick = tick_n;
      m_alarm = alarm_n;
   endtask

   task automatic step();
      @(posedge ap_clk);
      model_edge();
      @(negedge ap_clk);
      cyc++;
      if (alarm === 1'b1) alarm_seen++;
      if (tick === 1'b1) tick_seen++;
      chk("hh", 32'(hh), 32'(m_disp / 3600));
      chk("mm", 32'(mm), 32'((m_disp / 60) % 60));
      chk("ss", 32'(ss), 32'(m_disp % 60));
      chk("tick", 32'(tick), 32'(m_tick));
      chk("running", 32'(running), 32'(m_st == ST_RUN));
      chk("alarm", 32'(alarm), 32'(m_alarm));
      chk("zero", 32'(zero), 32'(m_zero));
   endtask

   task automatic wait_tick(input int bound);
      bit got;
      got = 1'b0;
      for (int n = 0; n < bound && !got; n++) begin
         step();
         if (tick === 1'b1) got = 1'b1;
      end
      chk("tick_timeout", 32'(got), 32'd1);
   endtask

   initial begin
      int last, held, r;
      ap_rst = 1'b1; clear = 1'b0; start_r = 1'b0; down = 1'b0; load = 1'b0; lap = 1'b0;
      load_hh = '0; load_mm = '0; load_ss = '0;
      alarm_hh = 8'd99; alarm_mm = 8'd99; alarm_ss = 8'd99;
      step();
      step();
      chk("rst_hh", 32'(hh), 32'd0);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
      ap_rst = 1'b0;

      // Plan 1: count up through the first minute, ticks every TICK_DIV cycles.
      start_r = 1'b1;
      tick_seen = 0;
      last = -1;
      for (int n = 0; n < TICK_DIV * 61 + 20 && tick_seen < 61; n++) begin
         step();
         if (tick === 1'b1) begin
            if (last >= 0) chk("tick_gap", 32'(cyc - last), 32'(TICK_DIV));
            last = cyc;
         end
      end
      chk("p1_hh", 32'(hh), 32'd0);
      chk("p1_mm", 32'(mm), 32'd1);
      chk("p1_ss", 32'(ss), 32'd1);
      chk("p1_running", 32'(running), 32'd1);

      // Plan 2: hour wrap from 23:59:58.
      load = 1'b1; load_hh = 8'd23; load_mm = 8'd59; load_ss = 8'd58;
      step();
      load = 1'b0;
      wait_tick(3 * TICK_DIV);
      chk("p2_a", 32'({hh, mm, ss}), {8'd0, 8'd23, 8'd59, 8'd59});
      wait_tick(3 * TICK_DIV);
      chk("p2_b", 32'({hh, mm, ss}), 32'd0);
      wait_tick(3 * TICK_DIV);
      chk("p2_c", 32'({hh, mm, ss}), 32'd1);

      // Plan 3: count down to DONE, start_r ignored afterwards.
      down = 1'b1;
      load = 1'b1; load_hh = 8'd0; load_mm = 8'd0; load_ss = 8'd2;
      step();
      load = 1'b0;
      wait_tick(3 * TICK_DIV);
      chk("p3_one", 32'(ss), 32'd1);
      wait_tick(3 * TICK_DIV);
      chk("p3_zero_ss", 32'(ss), 32'd0);
      chk("p3_zero_flag", 32'(zero), 32'd1);
      chk("p3_running", 32'(running), 32'd0);
      for (int n = 0; n < 20; n++) step();
      chk("p3_still_done", 32'({zero, running}), 32'b10);
      chk("p3_still_ss", 32'(ss), 32'd0);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("p3_cleared", 32'(zero), 32'd0);

      // Plan 4: alarm at 00:00:03 and lap hold/release.
      down = 1'b0;
      alarm_hh = 8'd0; alarm_mm = 8'd0; alarm_ss = 8'd3;
      alarm_seen = 0;
      for (int k = 0; k < 10 && ss != 8'd5; k++) wait_tick(3 * TICK_DIV);
      chk("p4_at5", 32'(ss), 32'd5);
      lap = 1'b1;
      step();
      lap = 1'b0;
      for (int k = 0; k < 3; k++) wait_tick(3 * TICK_DIV);
      chk("p4_held", 32'(ss), 32'd5);
      lap = 1'b1;
      step();
      lap = 1'b0;
      chk("p4_release", 32'(ss), 32'd8);
      chk("p4_alarm_once", 32'(alarm_seen), 32'd1);

      // Plan 5: pause with a partial second pending.
      for (int n = 0; n < 20 && !(m_st == ST_RUN && m_pre == 2); n++) step();
      chk("p5_pre2", 32'(m_pre), 32'd2);
      start_r = 1'b0;
      held = int'(ss);
      for (int n = 0; n < 10; n++) step();
      chk("p5_paused_ss", 32'(ss), 32'(held));
      chk("p5_paused_run", 32'(running), 32'd0);
      start_r = 1'b1;
      wait_tick(3 * TICK_DIV);
      chk("p5_resumed_ss", 32'(ss), 32'(held + 1));

      // Plan 6: priorities and saturation.
      load = 1'b1; clear = 1'b1; load_hh = 8'd70; load_mm = 8'd70; load_ss = 8'd70;
      step();
      load = 1'b0; clear = 1'b0;
      step();
      chk("p6_clear_wins", 32'({hh, mm, ss}), 32'd0);
      load = 1'b1;
      step();
      load = 1'b0;
      step();
      chk("p6_sat", 32'({hh, mm, ss}), {8'd0, 8'd23, 8'd59, 8'd59});
      for (int n = 0; n < 10; n++) step();
      ap_rst = 1'b1;
      step();
      ap_rst = 1'b0;
      chk("p6_rst_time", 32'({hh, mm, ss}), 32'd0);
      chk("p6_rst_run", 32'(running), 32'd0);

      // Random phase.
      for (int n = 0; n < 3000; n++) begin
         r = int'($urandom_range(0, 999));
         ap_rst = (r < 2);
         clear  = (r >= 2 && r < 8);
         load   = (r >= 8 && r < 30);
         lap    = (r >= 30 && r < 55);
         start_r = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 199) == 0) down = ~down;
         if (load) begin
            load_hh = ($urandom_range(0, 1) != 0) ? 8'd0 : 8'($urandom_range(0, 26));
            load_mm = ($urandom_range(0, 1) != 0) ? 8'd0 : 8'($urandom_range(0, 63));
            load_ss = 8'($urandom_range(0, 63));
            alarm_hh = load_hh;
            alarm_mm = load_mm;
            alarm_ss = 8'($urandom_range(0, 63));
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
